// File: rtl/simon_seq_engine.sv
// simon_seq_engine: replays the stored Simon pattern on the LEDs and checks player input against it.
// Define SIMON_SEQ_ECHO_EN to echo each matched player input on the LEDs for DWELL cycles (C_ECHO state).
module simon_seq_engine #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned DWELL  = 8,
  parameter int unsigned GAP    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_play,
  input  logic              i_cmd_check,
  input  logic              i_cmd_abort,
  input  logic [ADDR_W-1:0] i_last_idx,
  output logic [ADDR_W-1:0] o_mem_raddr,
  input  logic [PAT_W-1:0]  i_mem_rdata,
  input  logic              i_in_valid,
  input  logic [PAT_W-1:0]  i_in_pattern,
  output logic              o_in_ready,
  output logic [PAT_W-1:0]  o_led_pattern,
  output logic              o_busy,
  output logic              o_seq_done,
  output logic              o_check_ok,
  output logic              o_check_fail
);

  // One down-counter serves both the dwell and the gap timing.
  localparam int unsigned CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_P_FETCH,
    S_P_LOAD,
    S_P_SHOW,
    S_P_GAP,
    S_C_FETCH,
    S_C_LOAD,
    S_C_WAIT
`ifdef SIMON_SEQ_ECHO_EN
    , S_C_ECHO
`endif
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_last;
  logic [PAT_W-1:0]  r_expected;
  logic [CNT_W-1:0]  r_cnt;
`ifdef SIMON_SEQ_ECHO_EN
  logic              r_final;
`endif
  logic              w_last;

  assign w_last      = (r_idx == r_last);
  assign o_mem_raddr = r_idx;

  // Sequencer FSM; led_pattern doubles as the shown-pattern latch during playback.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_last        <= '0;
      r_expected    <= '0;
      r_cnt         <= '0;
`ifdef SIMON_SEQ_ECHO_EN
      r_final       <= 1'b0;
`endif
      o_in_ready    <= 1'b0;
      o_led_pattern <= '0;
      o_busy        <= 1'b0;
      o_seq_done    <= 1'b0;
      o_check_ok    <= 1'b0;
      o_check_fail  <= 1'b0;
    end else begin
      o_seq_done   <= 1'b0;
      o_check_ok   <= 1'b0;
      o_check_fail <= 1'b0;
      if (i_cmd_abort && (r_state != S_IDLE)) begin
        r_state       <= S_IDLE;
        r_idx         <= '0;
        o_led_pattern <= '0;
        o_busy        <= 1'b0;
        o_in_ready    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_cmd_play || i_cmd_check) begin
              r_idx   <= '0;
              r_last  <= i_last_idx;
              o_busy  <= 1'b1;
              r_state <= i_cmd_play ? S_P_FETCH : S_C_FETCH;
            end
          end
          S_P_FETCH: r_state <= S_P_LOAD;
          S_P_LOAD: begin
            o_led_pattern <= i_mem_rdata;
            r_cnt         <= CNT_W'(DWELL - 1);
            r_state       <= S_P_SHOW;
          end
          S_P_SHOW: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else begin
              o_led_pattern <= '0;
              if (w_last) begin
                r_state    <= S_IDLE;
                o_busy     <= 1'b0;
                o_seq_done <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
                if (GAP == 0) begin
                  r_state <= S_P_FETCH;
                end else begin
                  r_cnt   <= CNT_W'(GAP - 1);
                  r_state <= S_P_GAP;
                end
              end
            end
          end
          S_P_GAP: begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            else             r_state <= S_P_FETCH;
          end
          S_C_FETCH: r_state <= S_C_LOAD;
          S_C_LOAD: begin
            r_expected <= i_mem_rdata;
            o_in_ready <= 1'b1;
            r_state    <= S_C_WAIT;
          end
          S_C_WAIT: begin
            if (i_in_valid) begin
              o_in_ready <= 1'b0;
              if (i_in_pattern != r_expected) begin
                r_state      <= S_IDLE;
                o_busy       <= 1'b0;
                o_seq_done   <= 1'b1;
                o_check_fail <= 1'b1;
              end else begin
`ifdef SIMON_SEQ_ECHO_EN
                o_led_pattern <= i_in_pattern;
                r_cnt         <= CNT_W'(DWELL - 1);
                r_final       <= w_last;
                if (!w_last) r_idx <= r_idx + 1'b1;
                r_state       <= S_C_ECHO;
`else
                if (w_last) begin
                  r_state    <= S_IDLE;
                  o_busy     <= 1'b0;
                  o_seq_done <= 1'b1;
                  o_check_ok <= 1'b1;
                end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_C_FETCH;
                end
`endif
              end
            end
          end
`ifdef SIMON_SEQ_ECHO_EN
          S_C_ECHO: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else begin
              o_led_pattern <= '0;
              if (r_final) begin
                r_state    <= S_IDLE;
                o_busy     <= 1'b0;
                o_seq_done <= 1'b1;
                o_check_ok <= 1'b1;
              end else begin
                r_state <= S_C_FETCH;
              end
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_seq_engine.sv
// Scoreboard bench for simon_seq_engine: directed Simon scenarios plus randomized play/check runs.
module tb_simon_seq_engine;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned DWELL  = 8;
  localparam int unsigned GAP    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_play = 1'b0, cmd_check = 1'b0, cmd_abort = 1'b0;
  logic [ADDR_W-1:0] last_idx = '0;
  logic [ADDR_W-1:0] mem_raddr;
  logic [PAT_W-1:0]  mem_rdata;
  logic              in_valid = 1'b0;
  logic [PAT_W-1:0]  in_pattern = '0;
  logic              in_ready, busy, seq_done, check_ok, check_fail;
  logic [PAT_W-1:0]  led_pattern;

  logic [PAT_W-1:0]  mem [64];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { bit ok; bit fail; int dur; } done_t;
  typedef struct { logic [PAT_W-1:0] pat; int len; } run_t;
  done_t q_done[$];
  run_t  q_run[$];
  bit    run_chk_en = 1'b1;

  simon_seq_engine #(.ADDR_W(ADDR_W), .PAT_W(PAT_W), .DWELL(DWELL), .GAP(GAP)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_play(cmd_play), .i_cmd_check(cmd_check),
    .i_cmd_abort(cmd_abort), .i_last_idx(last_idx), .o_mem_raddr(mem_raddr),
    .i_mem_rdata(mem_rdata), .i_in_valid(in_valid), .i_in_pattern(in_pattern),
    .o_in_ready(in_ready), .o_led_pattern(led_pattern), .o_busy(busy),
    .o_seq_done(seq_done), .o_check_ok(check_ok), .o_check_fail(check_fail)
  );

  always #5 clk = ~clk;

  // Synchronous-read pattern memory model.
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes completion pulses and LED runs against the expectation queues.
  int               busy_cnt = 0;
  int               cur_len  = 0;
  logic [PAT_W-1:0] cur_pat  = '0;

  task automatic end_run();
    run_t e;
    if (run_chk_en) begin
      if (q_run.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_led_run: got pattern %0h for %0d cycles expected none", cur_pat, cur_len);
      end else begin
        e = q_run.pop_front();
        check("led_run_pattern", 32'(cur_pat), 32'(e.pat));
        check("led_run_length", 32'(cur_len), 32'(e.len));
      end
    end
    cur_len = 0;
  endtask

  always @(negedge clk) begin
    done_t d;
    if (rst) begin
      busy_cnt = 0;
      cur_len  = 0;
    end else begin
      if (busy === 1'b1) begin
        busy_cnt++;
      end else if (seq_done === 1'b1) begin
        if (q_done.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_seq_done: got ok=%0b fail=%0b expected no pulse", check_ok, check_fail);
        end else begin
          d = q_done.pop_front();
          check("done_check_ok", 32'(check_ok), 32'(d.ok));
          check("done_check_fail", 32'(check_fail), 32'(d.fail));
          if (d.dur >= 0) check("busy_duration", 32'(busy_cnt), 32'(d.dur));
        end
        busy_cnt = 0;
      end else begin
        busy_cnt = 0;
      end
      if (led_pattern !== '0 && !$isunknown(led_pattern)) begin
        if (cur_len != 0 && led_pattern != cur_pat) end_run();
        cur_pat = led_pattern;
        cur_len++;
      end else if (cur_len > 0) begin
        end_run();
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cmd(input bit p, input bit c, input logic [ADDR_W-1:0] l);
    cmd_play = p; cmd_check = c; last_idx = l;
    step();
    cmd_play = 1'b0; cmd_check = 1'b0; last_idx = ADDR_W'($urandom);
  endtask

  function automatic int play_cycles(input int l);
    return (l + 1) * (2 + DWELL) + l * GAP;
  endfunction

  task automatic push_play(input int l);
    for (int p = 0; p <= l; p++)
      if (mem[p] != '0) q_run.push_back('{mem[p], DWELL});
    q_done.push_back('{1'b0, 1'b0, play_cycles(l)});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy === 1'b1) begin
      step();
      n++;
      if (n > budget) begin
        n_chk++; n_fail++;
        $display("FAIL wait_idle_timeout: busy still %0b after %0d cycles", busy, n);
        break;
      end
    end
    step();
  endtask

  // Expected LED value in cycle n (cycle 1 follows the accept edge) of a playback ending at index l.
  function automatic logic [PAT_W-1:0] play_led(input int n, input int l);
    int per = 2 + DWELL + GAP;
    int p   = (n - 1) / per;
    int off = (n - 1) % per;
    if (p <= l && off >= 2 && off < 2 + DWELL) return mem[p];
    return '0;
  endfunction

  task automatic play_timed(input int l);
    int t = play_cycles(l);
    push_play(l);
    cmd(1'b1, 1'b0, ADDR_W'(l));
    for (int n = 1; n <= t + 1; n++) begin
      if (n > 1) step();
      check("play_led", 32'(led_pattern), 32'(play_led(n, l)));
      check("play_busy", 32'(busy), 32'(n <= t));
      check("play_seq_done", 32'(seq_done), 32'(n == t + 1));
    end
    step();
  endtask

  // Drives a check run; inputs match the memory except at bad_pos (-1 means all match).
  task automatic run_check(input int l, input int bad_pos, input logic [PAT_W-1:0] bad_pat);
    int stop = (bad_pos >= 0) ? bad_pos : l;
    int n;
    for (int k = 0; k < stop; k++) begin
`ifdef SIMON_SEQ_ECHO_EN
      if (mem[k] != '0) q_run.push_back('{mem[k], DWELL});
`endif
    end
`ifdef SIMON_SEQ_ECHO_EN
    if (bad_pos < 0 && mem[l] != '0) q_run.push_back('{mem[l], DWELL});
`endif
    q_done.push_back('{bad_pos < 0, bad_pos >= 0, -1});
    cmd(1'b0, 1'b1, ADDR_W'(l));
    for (int k = 0; k <= stop; k++) begin
      n = 0;
      while (in_ready !== 1'b1) begin
        in_valid = 1'($urandom);
        in_pattern = PAT_W'($urandom);
        step();
        n++;
        if (n > 200) begin
          n_chk++; n_fail++;
          $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles", in_ready, n);
          in_valid = 1'b0;
          return;
        end
      end
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      in_valid = 1'b1;
      in_pattern = (k == bad_pos) ? bad_pat : mem[k];
      step();
      in_valid = 1'b0;
      in_pattern = PAT_W'($urandom);
      check("in_ready_drop", 32'(in_ready), 32'd0);
    end
    if (bad_pos >= 0) begin
      check("fail_pulse", 32'(check_fail), 32'd1);
      check("fail_seq_done", 32'(seq_done), 32'd1);
      check("fail_ok_low", 32'(check_ok), 32'd0);
    end else begin
`ifndef SIMON_SEQ_ECHO_EN
      check("ok_pulse", 32'(check_ok), 32'd1);
      check("ok_seq_done", 32'(seq_done), 32'd1);
      check("ok_fail_low", 32'(check_fail), 32'd0);
`endif
    end
    wait_idle(400);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"}, 32'(led_pattern), 32'd0);
    check({tag, "_raddr"}, 32'(mem_raddr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_done"}, 32'(seq_done), 32'd0);
    check({tag, "_ok"}, 32'(check_ok), 32'd0);
    check({tag, "_fail"}, 32'(check_fail), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = PAT_W'($urandom);
    mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;

    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("reset");

    play_timed(2);
    run_check(3, -1, '0);
    run_check(3, 1, 4'b0100);
    check("fail_in_ready_after", 32'(in_ready), 32'd0);

    // Simultaneous commands: playback wins.
    push_play(1);
    cmd(1'b1, 1'b1, ADDR_W'(1));
    wait_idle(400);

    // Check command during playback is ignored.
    push_play(2);
    cmd(1'b1, 1'b0, ADDR_W'(2));
    repeat (5) step();
    cmd(1'b0, 1'b1, ADDR_W'(3));
    wait_idle(400);

    // Abort during P_SHOW.
    run_chk_en = 1'b0;
    cmd(1'b1, 1'b0, ADDR_W'(3));
    n = 0;
    while (led_pattern === '0 && n < 50) begin step(); n++; end
    check("abort_reached_show", 32'(led_pattern != '0), 32'd1);
    step();
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    check("abort_led", 32'(led_pattern), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_seq_done", 32'(seq_done), 32'd0);
    check("abort_idx", 32'(mem_raddr), 32'd0);
    repeat (3) step();
    run_chk_en = 1'b1;

    // Reset while waiting for player input.
    cmd(1'b0, 1'b1, ADDR_W'(3));
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin step(); n++; end
    check("rst_reached_wait", 32'(in_ready), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");
    step();

    // Randomized play/check runs against random memory contents.
    for (int it = 0; it < 24; it++) begin
      int l;
      int bad;
      for (int i = 0; i < 8; i++) mem[i] = PAT_W'($urandom);
      l = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 0) begin
        push_play(l);
        cmd(1'b1, 1'b0, ADDR_W'(l));
        wait_idle(400);
      end else begin
        bad = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, l);
        run_check(l, bad, (bad >= 0) ? (mem[bad] ^ PAT_W'($urandom_range(1, 15))) : '0);
      end
    end

    repeat (3) step();
    check("done_queue_drained", 32'(q_done.size()), 32'd0);
    check("run_queue_drained", 32'(q_run.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_seq_engine.md
Name: simon_seq_engine

Overview:
- Sequencing engine under the Simon game controller; owns the pattern-memory read port.
- Replays the stored pattern on the LEDs for PLAYBACK, with fixed dwell and gap timing.
- Checks player inputs one by one against the stored pattern for REPEAT.
- The game controller issues single-cycle commands and receives done, ok and fail pulses.

Parameters:
- ADDR_W, 6: pattern memory address width; maximum pattern length 2^ADDR_W.
- PAT_W, 4: pattern/button width.
- DWELL, 8: cycles each pattern is shown during playback; must be >= 1.
- GAP, 2: blank cycles between shown patterns; 0 removes the GAP state.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_play  in  1  one-cycle pulse: start playback
- cmd_check  in  1  one-cycle pulse: start input check
- cmd_abort  in  1  stop any operation
- last_idx  in  ADDR_W  index of the last stored pattern; sampled when a command is accepted
- mem_raddr  out  ADDR_W  pattern memory read address
- mem_rdata  in  PAT_W  pattern memory data; valid the cycle after mem_raddr is held
- in_valid  in  1  player pattern strobe
- in_pattern  in  PAT_W  player pattern
- in_ready  out  1  engine is waiting for a player pattern
- led_pattern  out  PAT_W  LED drive
- busy  out  1  operation in progress
- seq_done  out  1  one-cycle pulse when play or check completes
- check_ok  out  1  one-cycle pulse, all inputs matched
- check_fail  out  1  one-cycle pulse, mismatch

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst is sampled on the clk rising edge and overrides everything, including mid-operation.
- Reset values: state=IDLE, idx=0, mem_raddr=0, led_pattern=0, and in_ready, busy, seq_done, check_ok, check_fail all 0.
- All outputs are registered. mem_raddr always equals the idx register.
- States: IDLE, P_FETCH, P_LOAD, P_SHOW, P_GAP, C_FETCH, C_LOAD, C_WAIT, plus C_ECHO (optional feature only).
- IDLE:
  - cmd_play: idx=0, last_q=last_idx, go to P_FETCH.
  - cmd_check (with no cmd_play): same latching, go to C_FETCH.
  - Both commands in the same cycle: play wins.
  - Commands while busy=1 are ignored.
- P_FETCH: 1 cycle; address held.
- P_LOAD: 1 cycle; latch mem_rdata into shown_q; load dwell counter = DWELL-1.
- P_SHOW:
  - led_pattern = shown_q; counter decrements.
  - At 0 with idx==last_q: go to IDLE and pulse seq_done.
  - Otherwise idx++ and go to P_GAP (or directly to P_FETCH if GAP=0).
- P_GAP: led_pattern=0 for GAP cycles, then P_FETCH.
- Playback busy duration: (last_q+1)*(2+DWELL) + last_q*GAP cycles. seq_done is high in the first IDLE cycle, with busy=0.
- C_FETCH, C_LOAD: as in playback; C_LOAD latches expected_q.
- C_WAIT: in_ready=1 and led_pattern=0. On in_valid:
  - in_pattern != expected_q: pulse check_fail and seq_done; go to IDLE.
  - Match with idx==last_q: pulse check_ok and seq_done; go to IDLE.
  - Match otherwise: idx++ and go to C_FETCH.
- in_valid outside C_WAIT is ignored. in_ready drops the cycle after an input is accepted.
- cmd_abort in any non-IDLE state: go to IDLE next cycle; led_pattern=0, busy=0, no pulses, idx=0.
- idx is ADDR_W wide with no wrap. last_q bounds the index, so idx never exceeds 2^ADDR_W-1.
- busy=1 in every non-IDLE state.

Optional Feature:
- Macro: SIMON_SEQ_ECHO_EN.
- Defined:
  - A matched non-final input enters C_ECHO; led_pattern = in_pattern for DWELL cycles, then C_FETCH.
  - A matched final input also echoes for DWELL cycles before check_ok and seq_done.
  - Mismatch never echoes.
- Undefined: C_ECHO does not exist; led_pattern stays 0 throughout check.

Test Plan:
- Common setup: DWELL=8, GAP=2; memory holds 0:0001, 1:0010, 2:0100, 3:1000.
- Reset: rst=1 for 1 clk -> all outputs 0, mem_raddr=0, busy=0.
- Playback: cmd_play with last_idx=2 ->
  - led 0001 in cycles 3-10, 0 in 11-12, 0010 in 15-22, 0100 in 27-34 (cycle 0 = accept edge);
  - seq_done=1 and busy=0 in cycle 35.
- Check pass: cmd_check with last_idx=3; feed 0001, 0010, 0100, 1000 each on in_ready -> check_ok=1 and seq_done=1 for one cycle; check_fail stays 0.
- Check fail: cmd_check with last_idx=3; feed 0001 then 0100 -> check_fail=1 and seq_done=1 one cycle later; in_ready=0 afterwards.
- Arbitration and abort:
  - cmd_play and cmd_check together -> playback runs.
  - cmd_check during playback -> ignored.
  - cmd_abort in P_SHOW -> led=0 and busy=0 next cycle, no seq_done.
- Reset mid-check and echo:
  - rst in C_WAIT -> IDLE next cycle, all outputs 0.
  - With SIMON_SEQ_ECHO_EN, a matched 0001 is shown on led for 8 cycles before in_ready returns.
